delay_req_arbiter: RTL and testbench

- Shares one delay_master between n_req requesters, such as several dsp_core instances or a core plus a debug/readback port.
- Serialises delay read and write requests with round-robin priority.
- Holds a grant across a read-then-write pair so that a tap update is atomic.
- Routes the master's read data and write acks back to the granted requester only.

---
 rtl/delay_req_arbiter_pkg.sv | 23 ++
 rtl/delay_req_arbiter_rr_pick.sv | 30 +++
 rtl/delay_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_delay_req_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_req_arbiter_pkg.sv
// Shared types and defaults for the delay_master request arbiter.
package delay_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Index width for a vector of n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_req_arbiter_rr_pick.sv
// Round-robin pick: first set pending bit at or above rr_ptr, wrapping at n_req.
module delay_req_arbiter_rr_pick
  import delay_req_arbiter_pkg::*;
#(
  parameter int unsigned n_req = 4,
  localparam int unsigned IW = idx_width(n_req)
) (
  input  logic [n_req-1:0] pending,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    grant,
  output logic             any
);

  int unsigned pos;

  // Walk the rotated request vector and keep the first hit, already unrotated.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < n_req; k++) begin
      pos = (32'(rr_ptr) + k) % n_req;
      if (!any && pending[IW'(pos)]) begin
        any   = 1'b1;
        grant = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/delay_req_arbiter.sv
// Round-robin arbiter sharing one delay_master between n_req requesters.
// A requester asserting read and write together gets an atomic read-then-write.
// Optional WAIT timeout with sticky error: define DELAY_ARB_TIMEOUT_EN.
module delay_req_arbiter
  import delay_req_arbiter_pkg::*;
#(
  parameter int unsigned data_width     = 16,
  parameter int unsigned n_req          = 4,
  parameter int unsigned timeout_cycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [n_req-1:0]            req_read,
  input  logic [n_req-1:0]            req_write,
  input  logic [n_req*data_width-1:0] req_handle,
  input  logic [n_req*data_width-1:0] req_write_data,
  input  logic [n_req*data_width-1:0] req_write_inc,
  output logic [data_width-1:0]       req_read_data,
  output logic [n_req-1:0]            req_read_ready,
  output logic [n_req-1:0]            req_write_ack,
  output logic                        m_read_req,
  output logic                        m_write_req,
  output logic [data_width-1:0]       m_handle,
  output logic [data_width-1:0]       m_write_data,
  output logic [data_width-1:0]       m_write_inc,
  input  logic [data_width-1:0]       m_read_data,
  input  logic                        m_read_valid,
  input  logic                        m_write_ack,
  output logic                        busy,
  output logic                        error
);

  localparam int unsigned DW = data_width;
  localparam int unsigned IW = idx_width(n_req);
  localparam logic [n_req-1:0] ONE = n_req'(1);

  arb_state_t    state;
  arb_op_t       op;
  logic          rmw_write;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] rr_next;

  logic [DW-1:0] h_arr [n_req];
  logic [DW-1:0] d_arr [n_req];
  logic [DW-1:0] i_arr [n_req];

  // Unpack per-requester operand buses.
  for (genvar gi = 0; gi < n_req; gi++) begin : g_unpack
    assign h_arr[gi] = req_handle[gi*DW +: DW];
    assign d_arr[gi] = req_write_data[gi*DW +: DW];
    assign i_arr[gi] = req_write_inc[gi*DW +: DW];
  end

  delay_req_arbiter_rr_pick #(.n_req(n_req)) u_rr_pick (
    .pending (req_read | req_write),
    .rr_ptr  (rr_ptr),
    .grant   (pick_idx),
    .any     (pick_any)
  );

  assign rr_next = (grant == IW'(n_req - 1)) ? '0 : grant + IW'(1);

`ifdef DELAY_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(timeout_cycles + 1);
  logic [CW-1:0] wait_cnt;
  logic          timed_out;
  assign timed_out = (wait_cnt == CW'(timeout_cycles - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout_cycles != 0);
  assign error = 1'b0;
`endif

  // Arbiter FSM: grant, issue one master request, wait, respond to the grantee.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB_IDLE;
      op             <= OP_READ;
      rmw_write      <= 1'b0;
      grant          <= '0;
      rr_ptr         <= '0;
      m_read_req     <= 1'b0;
      m_write_req    <= 1'b0;
      m_handle       <= '0;
      m_write_data   <= '0;
      m_write_inc    <= '0;
      req_read_data  <= '0;
      req_read_ready <= '0;
      req_write_ack  <= '0;
      busy           <= 1'b0;
`ifdef DELAY_ARB_TIMEOUT_EN
      wait_cnt       <= '0;
      error          <= 1'b0;
`endif
    end else begin
      m_read_req     <= 1'b0;
      m_write_req    <= 1'b0;
      req_read_ready <= '0;
      req_write_ack  <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant        <= pick_idx;
            m_handle     <= h_arr[pick_idx];
            m_write_data <= d_arr[pick_idx];
            m_write_inc  <= i_arr[pick_idx];
            busy         <= 1'b1;
            state        <= ARB_ISSUE;
            if (req_read[pick_idx]) begin
              op         <= OP_READ;
              rmw_write  <= req_write[pick_idx];
              m_read_req <= 1'b1;
            end else begin
              op          <= OP_WRITE;
              rmw_write   <= 1'b0;
              m_write_req <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          state <= ARB_WAIT;
`ifdef DELAY_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ARB_WAIT: begin
          if (op == OP_READ && m_read_valid) begin
            req_read_data  <= m_read_data;
            req_read_ready <= ONE << grant;
            state          <= ARB_DONE;
          end else if (op == OP_WRITE && m_write_ack) begin
            req_write_ack <= ONE << grant;
            state         <= ARB_DONE;
          end
`ifdef DELAY_ARB_TIMEOUT_EN
          else if (timed_out) begin
            error <= 1'b1;
            state <= ARB_DONE;
            if (op == OP_READ) begin
              req_read_data  <= '0;
              req_read_ready <= ONE << grant;
            end else begin
              req_write_ack <= ONE << grant;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        ARB_DONE: begin
          if (op == OP_READ && rmw_write) begin
            op          <= OP_WRITE;
            rmw_write   <= 1'b0;
            m_write_req <= 1'b1;
            state       <= ARB_ISSUE;
          end else begin
            rr_ptr <= rr_next;
            busy   <= 1'b0;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_req_arbiter.sv
// Randomised and directed bench for delay_req_arbiter against a transaction-level model.
module tb_delay_req_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned T  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read, req_write;
  logic [N*DW-1:0] req_handle, req_write_data, req_write_inc;
  logic [DW-1:0]   req_read_data;
  logic [N-1:0]    req_read_ready, req_write_ack;
  logic            m_read_req, m_write_req;
  logic [DW-1:0]   m_handle, m_write_data, m_write_inc, m_read_data;
  logic            m_read_valid, m_write_ack;
  logic            busy, error;

  always #5 clk = ~clk;

  delay_req_arbiter #(.data_width(DW), .n_req(N), .timeout_cycles(T)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_handle(req_handle),
    .req_write_data(req_write_data), .req_write_inc(req_write_inc),
    .req_read_data(req_read_data), .req_read_ready(req_read_ready), .req_write_ack(req_write_ack),
    .m_read_req(m_read_req), .m_write_req(m_write_req), .m_handle(m_handle),
    .m_write_data(m_write_data), .m_write_inc(m_write_inc), .m_read_data(m_read_data),
    .m_read_valid(m_read_valid), .m_write_ack(m_write_ack), .busy(busy), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // requester-side stimulus state
  logic [N-1:0]  rq_read, rq_write;
  logic [DW-1:0] rq_h [N];
  logic [DW-1:0] rq_d [N];
  logic [DW-1:0] rq_i [N];
  bit rereq0, rand_req, spur_en, mute, use_fixed_data;
  int fixed_lat;
  logic [DW-1:0] fixed_data;

  // what the DUT sampled at the most recent edge
  logic [N-1:0]  p_read, p_write;
  logic [DW-1:0] p_h [N];
  logic [DW-1:0] p_d [N];
  logic [DW-1:0] p_i [N];
  logic          p_reset;

  // transaction-level model
  bit arb_idle, in_txn, t_rmw, t_timeout, err_exp;
  int t_grant, t_op, ptr;
  int resp_step = -1, pulse_step = -1, rmw_step = -1, idle_at = -1;
  logic [DW-1:0] t_h, t_d, t_i, t_rdata;
  int wait_grants [N];

  // observed event logs: 1 read issue, 2 write issue, 3 read ready, 4 write ack
  int            ev_log [$];
  logic [DW-1:0] hnd_log [$];
  logic [DW-1:0] rd_log [$];
  logic [N-1:0]  vec_log [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] pend, input int start);
    for (int k = 0; k < N; k++)
      if (pend[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_handle[i*DW +: DW]     = rq_h[i];
      req_write_data[i*DW +: DW] = rq_d[i];
      req_write_inc[i*DW +: DW]  = rq_i[i];
      p_h[i] = rq_h[i];
      p_d[i] = rq_d[i];
      p_i[i] = rq_i[i];
    end
    req_read  = rq_read;
    req_write = rq_write;
    p_read    = rq_read;
    p_write   = rq_write;
    p_reset   = reset;
  endtask

  // One clock: advance the model, compare every output, then drive the next inputs.
  task automatic step();
    logic [N-1:0]  e_rr, e_wa;
    logic          e_mrr, e_mwr;
    logic [DW-1:0] e_rd;
    bit issue, pulse;
    int g, lat;
    @(posedge clk);
    #1;
    cyc++;
    e_rr = '0; e_wa = '0; e_mrr = 1'b0; e_mwr = 1'b0; e_rd = '0;
    issue = 0; pulse = 0;
    if (p_reset) begin
      arb_idle = 1; in_txn = 0; ptr = 0; err_exp = 0;
      resp_step = -1; pulse_step = -1; rmw_step = -1; idle_at = -1;
      for (int i = 0; i < N; i++) wait_grants[i] = 0;
      chk("rst_m_handle", m_handle, 0);
      chk("rst_m_write_data", m_write_data, 0);
      chk("rst_m_write_inc", m_write_inc, 0);
      chk("rst_read_data", req_read_data, 0);
    end else begin
      if (cyc == rmw_step) begin
        issue = 1;
        t_op  = 1;
      end else if (arb_idle && (p_read | p_write) != '0) begin
        g = first_from(p_read | p_write, ptr);
        for (int i = 0; i < N; i++)
          if ((p_read[i] | p_write[i]) && i != g) wait_grants[i]++;
        chk("fairness", wait_grants[g] < N, 1);
        wait_grants[g] = 0;
        t_grant = g; t_h = p_h[g]; t_d = p_d[g]; t_i = p_i[g];
        t_op  = p_read[g] ? 0 : 1;
        t_rmw = p_read[g] & p_write[g];
        issue = 1; arb_idle = 0; in_txn = 1;
        if (rand_req) begin
          rq_h[g] = DW'($urandom); rq_d[g] = DW'($urandom); rq_i[g] = DW'($urandom);
        end
      end
      if (issue) begin
        e_mrr = (t_op == 0);
        e_mwr = (t_op == 1);
        resp_step = -1;
        if (mute) begin
`ifdef DELAY_ARB_TIMEOUT_EN
          pulse_step = cyc + T + 1;
          t_timeout  = 1;
`else
          pulse_step = -1;
`endif
        end else begin
          lat        = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
          resp_step  = cyc + lat;
          pulse_step = resp_step + 1;
          t_timeout  = 0;
          t_rdata    = use_fixed_data ? fixed_data : DW'($urandom);
        end
      end
      if (cyc == pulse_step) begin
        pulse = 1;
        if (t_op == 0) begin
          e_rr = N'(1) << t_grant;
          e_rd = t_timeout ? '0 : t_rdata;
        end else begin
          e_wa = N'(1) << t_grant;
        end
        if (t_timeout) err_exp = 1;
        if (t_op == 0 && t_rmw) begin
          rmw_step = cyc + 1;
        end else begin
          ptr = (t_grant + 1) % N;
          idle_at = cyc + 1;
          rq_read[t_grant]  = 1'b0;
          rq_write[t_grant] = 1'b0;
        end
      end
      if (cyc == idle_at) begin
        arb_idle = 1;
        in_txn   = 0;
      end
    end

    chk("m_read_req", m_read_req, e_mrr);
    chk("m_write_req", m_write_req, e_mwr);
    chk("busy", busy, in_txn);
    chk("req_read_ready", req_read_ready, e_rr);
    chk("req_write_ack", req_write_ack, e_wa);
    chk("error", error, err_exp);
    if (pulse && t_op == 0) chk("req_read_data", req_read_data, e_rd);
    if (in_txn) begin
      chk("m_handle", m_handle, t_h);
      chk("m_write_data", m_write_data, t_d);
      chk("m_write_inc", m_write_inc, t_i);
    end

    if (m_read_req)  begin ev_log.push_back(1); hnd_log.push_back(m_handle); end
    if (m_write_req) begin ev_log.push_back(2); hnd_log.push_back(m_handle); end
    if (|req_read_ready) begin
      ev_log.push_back(3); vec_log.push_back(req_read_ready); rd_log.push_back(req_read_data);
    end
    if (|req_write_ack) begin ev_log.push_back(4); vec_log.push_back(req_write_ack); end

    // requesters
    if (rereq0 && !rq_write[0] && !(pulse && t_grant == 0)) begin
      rq_write[0] = 1'b1;
      rq_h[0] = 16'h0100;
    end
    if (rand_req) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_read[i] && !rq_write[i] && !(pulse && t_grant == i) && $urandom_range(0, 3) == 0) begin
          lat = int'($urandom_range(0, 2));
          rq_read[i]  = (lat != 1);
          rq_write[i] = (lat != 0);
          rq_h[i] = DW'($urandom); rq_d[i] = DW'($urandom); rq_i[i] = DW'($urandom);
        end
      end
    end

    // master
    m_read_valid = 1'b0;
    m_write_ack  = 1'b0;
    m_read_data  = DW'($urandom);
    if (!p_reset && cyc == resp_step) begin
      if (t_op == 0) begin
        m_read_valid = 1'b1;
        m_read_data  = t_rdata;
      end else begin
        m_write_ack = 1'b1;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      if (in_txn) begin
        if (t_op == 0) m_write_ack = 1'b1;
        else           m_read_valid = 1'b1;
      end else if ($urandom_range(0, 1) == 0) begin
        m_read_valid = 1'b1;
      end else begin
        m_write_ack = 1'b1;
      end
    end
    drive_inputs();
  endtask

  task automatic clear_logs();
    ev_log.delete(); hnd_log.delete(); rd_log.delete(); vec_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; rq_read = '0; rq_write = '0;
    drive_inputs();
    step();
    reset = 1'b0;
    drive_inputs();
    step();
    clear_logs();
  endtask

  task automatic drain(input int max_steps, input string nm);
    int n = 0;
    while ((in_txn || rq_read != '0 || rq_write != '0) && n < max_steps) begin
      step();
      n++;
    end
    chk(nm, n < max_steps, 1);
  endtask

  function automatic int count_ev(input int code);
    int c = 0;
    foreach (ev_log[k]) if (ev_log[k] == code) c++;
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rereq0 = 0; rand_req = 0; spur_en = 0; mute = 0; use_fixed_data = 0;
    fixed_lat = 0; fixed_data = '0;
    rq_read = '0; rq_write = '0;
    for (int i = 0; i < N; i++) begin rq_h[i] = '0; rq_d[i] = '0; rq_i[i] = '0; end
    m_read_valid = 1'b0; m_write_ack = 1'b0; m_read_data = '0;
    reset = 1'b1;
    drive_inputs();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_read_ready, 0);

    // single read from requester 1
    do_reset();
    fixed_lat = 2; use_fixed_data = 1; fixed_data = 16'h1234;
    rq_read[1] = 1'b1; rq_h[1] = 16'd3;
    drive_inputs();
    drain(50, "single_read_done");
    chk("single_read_events", ev_log.size(), 2);
    if (rd_log.size() == 1) begin
      chk("single_read_data", rd_log[0], 16'h1234);
      chk("single_read_vec", vec_log[0], 4'b0010);
      chk("single_read_handle", hnd_log[0], 3);
    end else chk("single_read_pulses", rd_log.size(), 1);

    // simultaneous writes from 0, 2, 3
    do_reset();
    use_fixed_data = 0; fixed_lat = 1;
    for (int i = 0; i < N; i++) begin rq_h[i] = DW'(10 + i); rq_d[i] = DW'($urandom); rq_i[i] = DW'(i); end
    rq_write = 4'b1101;
    drive_inputs();
    drain(60, "multi_write_done");
    chk("multi_write_events", ev_log.size(), 6);
    if (hnd_log.size() == 3 && vec_log.size() == 3) begin
      chk("multi_h0", hnd_log[0], 10); chk("multi_h1", hnd_log[1], 12); chk("multi_h2", hnd_log[2], 13);
      chk("multi_v0", vec_log[0], 4'b0001); chk("multi_v1", vec_log[1], 4'b0100); chk("multi_v2", vec_log[2], 4'b1000);
    end
    chk("multi_ptr_model", ptr, 0);

    // read-modify-write from requester 2
    do_reset();
    fixed_lat = 3;
    rq_read[2] = 1'b1; rq_write[2] = 1'b1; rq_h[2] = 16'd7; rq_d[2] = 16'hA5A5;
    drive_inputs();
    drain(60, "rmw_done");
    chk("rmw_events", ev_log.size(), 4);
    if (ev_log.size() == 4) begin
      chk("rmw_ev0", ev_log[0], 1); chk("rmw_ev1", ev_log[1], 3);
      chk("rmw_ev2", ev_log[2], 2); chk("rmw_ev3", ev_log[3], 4);
      chk("rmw_h0", hnd_log[0], 7); chk("rmw_h1", hnd_log[1], 7);
      chk("rmw_v0", vec_log[0], 4'b0100); chk("rmw_v1", vec_log[1], 4'b0100);
    end

    // fairness: requester 0 hammers, requester 1 asks once
    do_reset();
    fixed_lat = 1; rereq0 = 1;
    rq_write[0] = 1'b1; rq_h[0] = 16'h0100;
    drive_inputs();
    n = 0;
    while (hnd_log.size() == 0 && n < 20) begin step(); n++; end
    chk("fair_first_grant", n < 20, 1);
    rq_write[1] = 1'b1; rq_h[1] = 16'h0101;
    drive_inputs();
    n = 0;
    while (rq_write[1] && n < 40) begin step(); n++; end
    chk("fair_req1_served", n < 40, 1);
    rereq0 = 0;
    drain(40, "fair_done");
    if (hnd_log.size() >= 2) chk("fair_second_grant", hnd_log[1], 16'h0101);
    else chk("fair_grant_count", hnd_log.size(), 2);

    // master never answers
    do_reset();
    mute = 1;
    rq_read[0] = 1'b1; rq_h[0] = 16'd9;
    drive_inputs();
`ifdef DELAY_ARB_TIMEOUT_EN
    n = 0;
    while (count_ev(3) == 0 && n < 40) begin step(); n++; end
    chk("timeout_fired", n < 40, 1);
    if (rd_log.size() == 1) begin
      chk("timeout_data", rd_log[0], 0);
      chk("timeout_vec", vec_log[0], 4'b0001);
    end
    chk("timeout_error", error, 1);
    mute = 0;
    repeat (5) step();
    chk("timeout_error_sticky", error, 1);
    drain(40, "timeout_done");
`else
    repeat (1000) step();
    chk("no_timeout_busy", busy, 1);
    chk("no_timeout_events", ev_log.size(), 1);
    mute = 0;
`endif

    // reset in the middle of WAIT, then a late response
    do_reset();
    mute = 1;
    rq_read[3] = 1'b1; rq_h[3] = 16'd5;
    drive_inputs();
    repeat (4) step();
    chk("midwait_busy", busy, 1);
    reset = 1'b1; rq_read = '0;
    drive_inputs();
    step();
    chk("midwait_rst_busy", busy, 0);
    chk("midwait_rst_rreq", m_read_req, 0);
    reset = 1'b0;
    drive_inputs();
    m_read_valid = 1'b1; m_read_data = 16'hBEEF;
    step();
    repeat (4) step();
    chk("midwait_late_pulse", count_ev(3), 0);
    mute = 0;

    // randomised traffic with spurious master responses
    do_reset();
    fixed_lat = 0; spur_en = 1; rand_req = 1;
    repeat (3000) step();
    rand_req = 0;
    drain(300, "random_drain");
    chk("random_traffic", ev_log.size() > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
